// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared definitions for the pipeline front end: instruction
//               field positions, format codes, fetch defaults, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Fetch defaults
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

  // Instruction field bit positions
  localparam int COND_MSB = 31;
  localparam int COND_LSB = 28;
  localparam int FMT_MSB  = 27;
  localparam int FMT_LSB  = 26;
  localparam int CTRL_MSB = 25;
  localparam int CTRL_LSB = 21;
  localparam int SETC_BIT = 20;

  // Format field codes
  localparam logic [1:0] FMT_ALU = 2'b00;
  localparam logic [1:0] FMT_LS  = 2'b01;
  localparam logic [1:0] FMT_BR  = 2'b10;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_DROP  = 2'b10
  } fetch_state_e;

  // Force an address onto a word boundary
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry holding register for a fetched instruction that
//               arrives while the decode-facing output register is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic        drain,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Clear (redirect) wins over load, load wins over drain
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= 32'h0;
      pc    <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with request/ack memory handshake,
//               branch redirect, decode back-pressure and a one-entry skid.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [3:0]  if_cond,
  output logic [1:0]  if_fmt,
  output logic [4:0]  if_ctrl,
  output logic        if_setc
);

  fetch_state_e state;
  fetch_state_e state_nxt;
  logic [31:0]  pc;          // next useful fetch address
  logic [31:0]  drop_addr;   // address of the request being discarded
  logic         skid_valid;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;
  logic         ack_ok;
  logic         fetch_ack;
  logic         out_ready;
  logic         skid_load;

  // A request is only raised with room for its data, so once the skid is
  // full no request is outstanding and dropping imem_req withdraws nothing.
  assign imem_req  = (state == ST_DROP) || ((state == ST_FETCH) && !skid_valid);
  assign imem_addr = (state == ST_DROP) ? drop_addr : pc;
  assign ack_ok    = imem_req && imem_ack;
  assign fetch_ack = ack_ok && (state == ST_FETCH);
  assign out_ready = !if_valid || !id_stall;
  assign skid_load = !br_taken && fetch_ack && !out_ready;

  // Next-state: redirect with an unacknowledged request must drain it first
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (br_taken && imem_req && !imem_ack) state_nxt = ST_DROP;
      ST_DROP:  if (imem_ack) state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Program counter: redirect first, otherwise step on each useful ack
  always_ff @(posedge clk) begin
    if (rst)            pc <= RESET_PC;
    else if (br_taken)  pc <= align_word(br_target);
    else if (fetch_ack) pc <= pc + PC_STEP;
  end

  // Remember the in-flight address so it stays stable while being dropped
  always_ff @(posedge clk) begin
    if (rst)                    drop_addr <= RESET_PC;
    else if (state != ST_DROP)  drop_addr <= pc;
  end

  // Output register: skid drains ahead of new memory data to keep order
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= 32'h0;
    end else if (br_taken) begin
      if_valid <= 1'b0;
    end else if (out_ready) begin
      if (skid_valid) begin
        if_valid <= 1'b1;
        if_instr <= skid_instr;
        if_pc    <= skid_pc;
      end else if (fetch_ack) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= imem_addr;
      end else begin
        if_valid <= 1'b0;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .clear      (br_taken),
    .load       (skid_load),
    .load_instr (imem_rdata),
    .load_pc    (imem_addr),
    .drain      (out_ready),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  assign if_cond = if_instr[COND_MSB:COND_LSB];
  assign if_fmt  = if_instr[FMT_MSB:FMT_LSB];
  assign if_ctrl = if_instr[CTRL_MSB:CTRL_LSB];
  assign if_setc = if_instr[SETC_BIT];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A transaction-level
//               model keeps the ordered list of instructions owed to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        id_stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [3:0]  if_cond;
  logic [1:0]  if_fmt;
  logic [4:0]  if_ctrl;
  logic        if_setc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(T_RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target), .id_stall(id_stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_cond(if_cond), .if_fmt(if_fmt), .if_ctrl(if_ctrl), .if_setc(if_setc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  // Reference model: instructions fetched but not yet taken by decode
  item_t       q[$];
  logic [31:0] m_pc = T_RESET_PC;
  logic [31:0] m_stale_addr = 32'h0;
  bit          m_stale = 1'b0;
  bit          m_started = 1'b0;
  bit          m_in_reset = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare everything visible after the last edge against the model
  task automatic check_outputs();
    bit exp_req;
    exp_req = m_started && (m_stale || (q.size() < 2));
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    check("imem_addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
    if (exp_req)
      check("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
    check("if_valid", {31'b0, if_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      check("if_pc",    if_pc,    q[0].pc);
      check("if_instr", if_instr, q[0].instr);
      check("if_cond",  {28'b0, if_cond}, {28'b0, q[0].instr[31:28]});
      check("if_fmt",   {30'b0, if_fmt},  {30'b0, q[0].instr[27:26]});
      check("if_ctrl",  {27'b0, if_ctrl}, {27'b0, q[0].instr[25:21]});
      check("if_setc",  {31'b0, if_setc}, {31'b0, q[0].instr[20]});
    end
    if (m_in_reset) begin
      check("rst_if_instr",  if_instr,  32'h0);
      check("rst_if_pc",     if_pc,     32'h0);
      check("rst_imem_addr", imem_addr, T_RESET_PC);
    end
  endtask

  // One clock: check, drive inputs, advance the model, cross the edge
  task automatic step(input bit r, input bit a, input bit b,
                      input logic [31:0] tgt, input bit s, input logic [31:0] data);
    bit          req_now;
    bit          ack_eff;
    logic [31:0] addr_now;
    check_outputs();
    req_now  = m_started && (m_stale || (q.size() < 2));
    addr_now = m_stale ? m_stale_addr : m_pc;
    rst = r; imem_ack = a; br_taken = b; br_target = tgt; id_stall = s; imem_rdata = data;
    if (r) begin
      q.delete();
      m_pc = T_RESET_PC; m_stale = 1'b0; m_started = 1'b0; m_in_reset = 1'b1;
    end else begin
      m_in_reset = 1'b0;
      ack_eff = a && req_now;
      if (b) begin
        if (req_now && !ack_eff) begin
          m_stale = 1'b1;
          m_stale_addr = addr_now;
        end else begin
          m_stale = 1'b0;
        end
        q.delete();
        m_pc = tgt & ~32'h3;
      end else begin
        if (q.size() > 0 && !s) void'(q.pop_front());
        if (ack_eff) begin
          if (m_stale) m_stale = 1'b0;
          else begin
            q.push_back({m_pc, data});
            m_pc = m_pc + 32'd4;
          end
        end
      end
      m_started = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Zero-wait memory returning its address as data
  task automatic run_zero_wait(input int n);
    for (int i = 0; i < n; i++) step(1'b0, imem_req, 1'b0, 32'h0, 1'b0, imem_addr);
  endtask

  initial begin
    bit          found;
    logic [31:0] tgt;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    // Reset state, then straight-line zero-wait fetch
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    run_zero_wait(3);

    // Stall decode for three cycles while if_pc is 8, acks keep coming
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid && if_pc == 32'h8) found = 1'b1;
      else step(1'b0, imem_req, 1'b0, 32'h0, 1'b0, imem_addr);
    end
    check("reach_pc8", {31'b0, found}, 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, imem_req, 1'b0, 32'h0, 1'b1, imem_addr);
    run_zero_wait(4);

    // Redirect with request outstanding, the next ack is dropped
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
    run_zero_wait(4);

    // Redirect coincident with ack while decode is stalled
    step(1'b0, imem_req, 1'b0, 32'h0, 1'b1, imem_addr);
    step(1'b0, imem_req, 1'b1, 32'h0000_0200, 1'b1, 32'hBAD0_0BAD);
    run_zero_wait(3);

    // Fetch across the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h1234_5678);
    run_zero_wait(5);

    // Reset in the middle of a request, ack ignored, then restart
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF);
    run_zero_wait(4);

    // Random traffic: wait states, stalls, redirects, occasional reset
    for (int i = 0; i < 3000; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      step(($urandom_range(0, 400) == 0),
           imem_req && ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0),
           tgt,
           ($urandom_range(0, 2) == 0),
           $urandom);
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
